// File: rtl/request_arbiter.sv
// rtl/request_arbiter.sv - round-robin arbiter sharing one responder between four request FIFOs
//
// Purpose: picks a non-empty request FIFO in round-robin order, pops it and
// forwards the popped word to the responder as a one-cycle strobe. New
// grants are withheld while the response FIFO is full or almost full.
//
// Ports:
//   i_clk             clock, rising edge
//   i_reset           synchronous active-high reset
//   i_req_empty       per-lane empty flags of the request FIFOs
//   i_req_data        head words, lane i at [i*REQ_W +: REQ_W]
//   o_req_pop         one-hot pop strobe to the request FIFOs
//   i_out_full        response FIFO full
//   i_out_almost_full response FIFO almost full
//   o_req_out         request forwarded to the responder
//   o_req_valid       one-cycle strobe qualifying o_req_out
//   o_grant_id        lane that o_req_out came from
//   o_busy            high while in POP or ISSUE
//   o_issued_cnt      wrapping count of issued requests
module request_arbiter #(
  parameter int REQ_W = 12,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req_empty,
  input  logic [N_REQ*REQ_W-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_pop,
  input  logic                   i_out_full,
  input  logic                   i_out_almost_full,
  output logic [REQ_W-1:0]       o_req_out,
  output logic                   o_req_valid,
  output logic [1:0]             o_grant_id,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_issued_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [1:0]         r_rr_ptr,    w_rr_ptr_nxt;
  logic [1:0]         r_gsel,      w_gsel_nxt;
  logic [N_REQ-1:0]   r_req_pop,   w_req_pop_nxt;
  logic [REQ_W-1:0]   r_req_out,   w_req_out_nxt;
  logic               r_req_valid, w_req_valid_nxt;
  logic [1:0]         r_grant_id,  w_grant_id_nxt;
  logic               r_busy,      w_busy_nxt;
  logic [CNT_W-1:0]   r_issued_cnt, w_issued_cnt_nxt;

  logic               w_eligible;
  logic [1:0]         w_sel;
  logic [1:0]         w_idx;
  logic               w_found;

  // Backpressure only gates new grants; an in-flight pop always issues.
  assign w_eligible = (i_req_empty != {N_REQ{1'b1}}) && !i_out_full && !i_out_almost_full;

  // Search starts one past the last granted lane so the last winner is
  // considered last.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + k[1:0];
      if (!w_found && !i_req_empty[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_gsel_nxt       = r_gsel;
    w_req_pop_nxt    = '0;
    w_req_out_nxt    = r_req_out;
    w_req_valid_nxt  = 1'b0;
    w_grant_id_nxt   = r_grant_id;
    w_issued_cnt_nxt = r_issued_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_state_nxt   = ST_POP;
          w_req_pop_nxt = N_REQ'(1) << w_sel;
          w_gsel_nxt    = w_sel;
          w_rr_ptr_nxt  = w_sel;
        end
      end
      ST_POP: begin
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        // FIFO head of the granted lane is valid in this cycle.
        w_req_out_nxt    = i_req_data[int'(r_gsel)*REQ_W +: REQ_W];
        w_grant_id_nxt   = r_gsel;
        w_req_valid_nxt  = 1'b1;
        w_issued_cnt_nxt = r_issued_cnt + 1'b1;
        if (w_eligible) begin
          w_state_nxt   = ST_POP;
          w_req_pop_nxt = N_REQ'(1) << w_sel;
          w_gsel_nxt    = w_sel;
          w_rr_ptr_nxt  = w_sel;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= 2'd3;
      r_gsel       <= 2'd0;
      r_req_pop    <= '0;
      r_req_out    <= '0;
      r_req_valid  <= 1'b0;
      r_grant_id   <= 2'd0;
      r_busy       <= 1'b0;
      r_issued_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_gsel       <= w_gsel_nxt;
      r_req_pop    <= w_req_pop_nxt;
      r_req_out    <= w_req_out_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_busy       <= w_busy_nxt;
      r_issued_cnt <= w_issued_cnt_nxt;
    end
  end

  assign o_req_pop    = r_req_pop;
  assign o_req_out    = r_req_out;
  assign o_req_valid  = r_req_valid;
  assign o_grant_id   = r_grant_id;
  assign o_busy       = r_busy;
  assign o_issued_cnt = r_issued_cnt;

endmodule

// File: tb/tb_request_arbiter.sv
// tb/tb_request_arbiter.sv - directed self-checking bench for request_arbiter
module tb_request_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req_empty;
  logic [47:0] req_data;
  logic [3:0]  req_pop;
  logic        out_full;
  logic        out_almost_full;
  logic [11:0] req_out;
  logic        req_valid;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] issued_cnt;

  request_arbiter dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_req_empty       (req_empty),
    .i_req_data        (req_data),
    .o_req_pop         (req_pop),
    .i_out_full        (out_full),
    .i_out_almost_full (out_almost_full),
    .o_req_out         (req_out),
    .o_req_valid       (req_valid),
    .o_grant_id        (grant_id),
    .o_busy            (busy),
    .o_issued_cnt      (issued_cnt)
  );

  // Narrow-counter instance so the counter wrap is reached quickly.
  logic        w_reset;
  logic [3:0]  w_empty;
  logic [47:0] w_data;
  logic [3:0]  w_pop;
  logic        w_full;
  logic        w_afull;
  logic [11:0] w_out;
  logic        w_valid;
  logic [1:0]  w_grant;
  logic        w_busy;
  logic [3:0]  w_cnt;

  request_arbiter #(.CNT_W(4)) dut_w (
    .i_clk             (clk),
    .i_reset           (w_reset),
    .i_req_empty       (w_empty),
    .i_req_data        (w_data),
    .o_req_pop         (w_pop),
    .i_out_full        (w_full),
    .i_out_almost_full (w_afull),
    .o_req_out         (w_out),
    .o_req_valid       (w_valid),
    .o_grant_id        (w_grant),
    .o_busy            (w_busy),
    .o_issued_cnt      (w_cnt)
  );

  int n_checks;
  int n_err;
  int pulses;
  logic [11:0] t2_exp [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset;
    reset = 1'b1;
    step;
    step;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    t2_exp   = '{12'd659, 12'd979, 12'd1301, 12'd2039, 12'd659};

    reset = 1'b1; req_empty = 4'hF; req_data = '0; out_full = 1'b0; out_almost_full = 1'b0;
    w_reset = 1'b1; w_empty = 4'hF; w_data = '0; w_full = 1'b0; w_afull = 1'b0;
    step;
    step;

    // Reset state
    chk("rst_pop", 32'(req_pop), 0);
    chk("rst_out", 32'(req_out), 0);
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(issued_cnt), 0);

    // 1: single lane 2
    req_data  = {12'd0, 12'd17, 12'd0, 12'd0};
    req_empty = 4'b1011;
    reset     = 1'b0;
    step;
    chk("t1_pop", 32'(req_pop), 32'b0100);
    chk("t1_busy", 32'(busy), 1);
    req_empty = 4'hF;
    step;
    chk("t1_valid_early", 32'(req_valid), 0);
    step;
    chk("t1_valid", 32'(req_valid), 1);
    chk("t1_out", 32'(req_out), 17);
    chk("t1_grant", 32'(grant_id), 2);
    chk("t1_cnt", 32'(issued_cnt), 1);
    repeat (4) begin
      step;
      chk("t1_no_pop", 32'(req_pop), 0);
    end

    // 2: round robin over four busy lanes
    hold_reset;
    req_data  = {12'd2039, 12'd1301, 12'd979, 12'd659};
    req_empty = 4'b0000;
    reset     = 1'b0;
    step;
    chk("t2_pop0", 32'(req_pop), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("t2_gap", 32'(req_valid), 0);
      step;
      chk("t2_valid", 32'(req_valid), 1);
      chk("t2_out", 32'(req_out), 32'(t2_exp[k]));
      chk("t2_grant", 32'(grant_id), 32'(k % 4));
    end
    chk("t2_cnt", 32'(issued_cnt), 5);
    req_empty = 4'hF;
    repeat (4) step;
    chk("t2_drain_busy", 32'(busy), 0);

    // 3: almost-full raised during POP
    hold_reset;
    req_empty = 4'b1100;
    reset     = 1'b0;
    step;
    chk("t3_pop0", 32'(req_pop), 32'b0001);
    out_almost_full = 1'b1;
    step;
    step;
    chk("t3_valid", 32'(req_valid), 1);
    chk("t3_out", 32'(req_out), 659);
    chk("t3_grant", 32'(grant_id), 0);
    repeat (3) begin
      step;
      chk("t3_stall_pop", 32'(req_pop), 0);
      chk("t3_stall_busy", 32'(busy), 0);
    end
    out_almost_full = 1'b0;
    step;
    chk("t3_pop1", 32'(req_pop), 32'b0010);
    step;
    step;
    chk("t3_valid1", 32'(req_valid), 1);
    chk("t3_out1", 32'(req_out), 979);
    chk("t3_grant1", 32'(grant_id), 1);
    req_empty = 4'hF;
    repeat (4) step;

    // 4: full from reset
    hold_reset;
    out_full  = 1'b1;
    req_data  = {12'd49, 36'd0};
    req_empty = 4'b0111;
    reset     = 1'b0;
    repeat (4) begin
      step;
      chk("t4_stall_pop", 32'(req_pop), 0);
      chk("t4_stall_busy", 32'(busy), 0);
    end
    out_full = 1'b0;
    step;
    chk("t4_pop", 32'(req_pop), 32'b1000);
    req_empty = 4'hF;
    step;
    step;
    chk("t4_valid", 32'(req_valid), 1);
    chk("t4_out", 32'(req_out), 49);
    chk("t4_grant", 32'(grant_id), 3);
    chk("t4_cnt", 32'(issued_cnt), 1);

    // 5: reset during ISSUE
    hold_reset;
    req_data  = {36'd0, 12'd1943};
    req_empty = 4'b1110;
    reset     = 1'b0;
    step;
    chk("t5_pop", 32'(req_pop), 32'b0001);
    step;
    reset = 1'b1;
    step;
    chk("t5_valid", 32'(req_valid), 0);
    chk("t5_cnt", 32'(issued_cnt), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_out", 32'(req_out), 0);
    chk("t5_pop_clr", 32'(req_pop), 0);
    reset     = 1'b0;
    req_empty = 4'b0000;
    step;
    chk("t5_next_lane0", 32'(req_pop), 32'b0001);
    req_empty = 4'hF;
    step;
    step;
    chk("t5_valid2", 32'(req_valid), 1);
    chk("t5_out2", 32'(req_out), 1943);
    chk("t5_grant2", 32'(grant_id), 0);
    chk("t5_cnt2", 32'(issued_cnt), 1);

    // 6: counter wrap on the narrow instance, lane 1 only
    w_data  = {12'd0, 12'd0, 12'd941, 12'd0};
    w_empty = 4'b1101;
    w_reset = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 200 && pulses < 16; c++) begin
      step;
      if (w_valid) begin
        pulses++;
        chk("t6_out", 32'(w_out), 941);
        chk("t6_grant", 32'(w_grant), 1);
        chk("t6_cnt", 32'(w_cnt), 32'(pulses % 16));
      end
    end
    w_empty = 4'hF;
    chk("t6_pulses", 32'(pulses), 16);
    chk("t6_wrap", 32'(w_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/request_arbiter.md
Name: request_arbiter

Overview:
- Shares one responder between four request FIFOs, one per peer node in the PageRank sort fabric.
- Picks a non-empty request FIFO in round-robin order and pops it.
- Forwards the popped 12-bit request to the responder as a one-cycle strobe.
- Stops granting when the response FIFO is full or almost full, so a popped request is never dropped.

Parameters:
- REQ_W, 12, request word width (same as responder request input).
- N_REQ, 4, number of requesters (fixed at 4; SEL_W=2 derived).
- CNT_W, 16, width of the issued-request counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_empty  input  4  empty flag of each request FIFO; bit i = lane i.
- req_data  input  4*REQ_W  head words of the request FIFOs; lane i at [i*REQ_W +: REQ_W]. Valid the cycle after that lane's pop.
- req_pop  output  4  one-hot pop strobe to the request FIFOs.
- out_full  input  1  response FIFO full.
- out_almost_full  input  1  response FIFO almost full.
- req_out  output  REQ_W  request forwarded to the responder.
- req_valid  output  1  one-cycle strobe; req_out is valid while high.
- grant_id  output  2  lane the current req_out came from.
- busy  output  1  high while in POP or ISSUE.
- issued_cnt  output  CNT_W  total requests issued; wraps.

Behaviour:
- Every output is registered.
- Reset values: req_pop=0, req_out=0, req_valid=0, grant_id=0, busy=0, issued_cnt=0, state=IDLE, rr_ptr=3 (lane 0 has first priority).
- eligible = (req_empty != 4'b1111) && !out_full && !out_almost_full.
- sel = first lane with req_empty=0, searching rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4).
- IDLE:
  - if eligible: go to POP; req_pop <= onehot(sel); gsel <= sel; rr_ptr <= sel.
  - else stay in IDLE.
- POP (exactly 1 cycle):
  - req_pop is high this cycle; next state is ISSUE; req_pop <= 0.
- ISSUE (exactly 1 cycle), request FIFO head is valid:
  - req_out <= req_data[gsel]; grant_id <= gsel; req_valid <= 1; issued_cnt <= issued_cnt+1.
  - if eligible (evaluated on the current flags): go directly to POP with the same grant actions as IDLE; otherwise go to IDLE.
- req_valid is high for exactly one cycle per issued request. It is cleared on every cycle in which it was not set by ISSUE.
- Latency: eligible seen in cycle 0 → req_pop in cycle 1 → data sampled in cycle 2 → req_valid/req_out in cycle 3.
- Peak throughput: one request per 2 cycles.
- Backpressure:
  - out_full or out_almost_full blocks only new grants.
  - A request already in POP or ISSUE always completes and is issued. The almost_full margin of at least one word covers it.
- Pointer and fairness:
  - rr_ptr updates only on a grant.
  - A lane that is continuously non-empty is granted at least once in every 4 grants.
- A lane going empty in the same cycle as its evaluation is treated as empty (req_empty is sampled as presented).
- req_pop is never asserted on a lane whose req_empty=1 in the deciding cycle.
- issued_cnt wraps from 16'hFFFF to 0 with no flag.
- busy = (state != IDLE), registered together with the state.
- Reset mid-operation: all state returns to reset values on the next edge. A request popped but not yet issued is discarded; the bench must not expect it on req_out.

Test Plan:
1. Single lane: reset; lane 2 head=17, req_empty=4'b1011. Expect req_pop=4'b0100 in cycle 1, then req_out=17, grant_id=2, req_valid=1 in cycle 3, issued_cnt=1. Lane then goes empty: no further pops.
2. Round-robin: all lanes non-empty with heads 659, 979, 1301, 2039, held non-empty. Expect grant order 0,1,2,3,0, with req_valid pulses 2 cycles apart and req_out=659,979,1301,2039,659.
3. Almost-full stall: lanes 0 and 1 non-empty; raise out_almost_full=1 during POP of lane 0. Expect req_out=659 still issued, then no req_pop while it is high. Drop it: next grant goes to lane 1 (req_out=979).
4. Full stall: out_full=1 from reset with lane 3 head=49 non-empty. Expect req_pop=0 and busy=0. Release out_full: req_out=49 appears 3 cycles later.
5. Reset in ISSUE: lane 0 head=1943; assert reset in the ISSUE cycle. Expect req_valid=0, issued_cnt=0, rr_ptr=3. Next grant is lane 0.
6. Counter wrap: preload by issuing 65536 requests from lane 1 (head=941). Expect issued_cnt to return to 0 after the 65536th req_valid.
